// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 160x100 video subsystem.
//   SCR_W / SCR_H   visible columns / rows; SCR_W is also the VRAM row stride
//   VRAM_AW         VRAM address width (16000 bytes fit in 14 bits)
//   color_t         8-bit RRRGGGBB pixel
//   state_t         drawing-engine FSM states
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int SCR_W   = 160;
   localparam int SCR_H   = 100;
   localparam int VRAM_AW = 14;

   // Sized copies so the clipping compares in the engine stay width-exact.
   localparam logic [8:0] SCR_W_9 = 9'(SCR_W);
   localparam logic [7:0] SCR_H_8 = 8'(SCR_H);

   typedef logic [7:0] color_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } state_t;

   // y*160 built from two shifts: 160 = 128 + 32.
   function automatic logic [VRAM_AW-1:0] row_offset(input logic [6:0] y);
      return VRAM_AW'({y, 7'b0}) + VRAM_AW'({y, 5'b0});
   endfunction

endpackage

// File: rtl/rect_fill.sv
// ---------------------------------------------------------------------------
// rect_fill
// Rectangle-fill drawing engine feeding the 160x100 VRAM, one byte per clock.
// Rectangles are clipped to the screen; writes go out in raster order at
// addr = y*160 + x.
//
// Optional build macro RECT_FILL_CHECKER_EN adds the cmd_checker input: when
// latched high the fill becomes a 4x4-cell checkerboard of colour and black,
// aligned to absolute screen coordinates. Timing is identical in both builds.
//
// Ports
//   pclk        clock, rising edge
//   reset_n     asynchronous active-low reset
//   cmd_valid   command present            cmd_ready  high only in IDLE
//   cmd_x/y     top-left corner            cmd_w/h    size in pixels/rows
//   cmd_color   fill colour (RRRGGGBB)     cmd_checker  (macro builds only)
//   vram_we/addr/data  write request, held while vram_wait is high
//   vram_wait   VRAM did not take the write this cycle
//   busy        high in FILL or DONE       done       one-cycle completion
// ---------------------------------------------------------------------------
module rect_fill
   import vga_pkg::*;
#(
   parameter int AW = VRAM_AW
) (
   input  logic          pclk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [7:0]    cmd_x,
   input  logic [6:0]    cmd_y,
   input  logic [7:0]    cmd_w,
   input  logic [6:0]    cmd_h,
   input  logic [7:0]    cmd_color,
`ifdef RECT_FILL_CHECKER_EN
   input  logic          cmd_checker,
`endif
   output logic          vram_we,
   output logic [AW-1:0] vram_addr,
   output logic [7:0]    vram_data,
   input  logic          vram_wait,
   output logic          busy,
   output logic          done
);

   state_t          state, state_nxt;

   logic [7:0]      x_start;    // column each row restarts from
   logic [8:0]      x_end;      // clipped, exclusive
   logic [7:0]      y_end;      // clipped, exclusive
   logic [7:0]      cx;
   logic [6:0]      cy;
   logic [AW-1:0]   row_base;   // cy*160, stepped by 160 per row
   color_t          color;
`ifdef RECT_FILL_CHECKER_EN
   logic            checker;
`endif

   logic [8:0]      x_sum, x_clip;
   logic [7:0]      y_sum, y_clip;
   logic            degenerate;
   logic            accept;
   logic            wr_done;
   logic            row_last;
   logic            rect_last;
   color_t          pix_data;

   // ---------------------------------------------------------------------
   // Command decode and loop-end detection
   // ---------------------------------------------------------------------
   assign x_sum  = {1'b0, cmd_x} + {1'b0, cmd_w};
   assign y_sum  = {1'b0, cmd_y} + {1'b0, cmd_h};
   assign x_clip = (x_sum > SCR_W_9) ? SCR_W_9 : x_sum;
   assign y_clip = (y_sum > SCR_H_8) ? SCR_H_8 : y_sum;

   assign degenerate = (cmd_w == 8'd0) || (cmd_h == 7'd0) ||
                       ({1'b0, cmd_x} >= SCR_W_9) || ({1'b0, cmd_y} >= SCR_H_8);

   assign accept    = cmd_valid && (state == IDLE);
   assign wr_done   = (state == FILL) && !vram_wait;
   assign row_last  = ({1'b0, cx} == (x_end - 9'd1));
   assign rect_last = row_last && ({1'b0, cy} == (y_end - 8'd1));

`ifdef RECT_FILL_CHECKER_EN
   assign pix_data = (checker && (cx[2] ^ cy[2])) ? 8'h00 : color;
`else
   assign pix_data = color;
`endif

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and outputs. Outputs decode from state alone, so reset
   // (which forces IDLE) clears the write port immediately.
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_nxt = state;
      cmd_ready = 1'b0;
      vram_we   = 1'b0;
      vram_addr = '0;
      vram_data = 8'h00;
      busy      = 1'b0;
      done      = 1'b0;

      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_nxt = degenerate ? DONE : FILL;
            end
         end
         FILL: begin
            busy      = 1'b1;
            vram_we   = 1'b1;
            vram_addr = row_base + AW'(cx);
            vram_data = pix_data;
            if (wr_done && rect_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Command latch and raster counters
   // ---------------------------------------------------------------------
   // NOTE: these datapath registers are reset too even though FILL always
   // reloads them, so the write port never shows X after reset.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         x_start  <= 8'd0;
         x_end    <= 9'd0;
         y_end    <= 8'd0;
         cx       <= 8'd0;
         cy       <= 7'd0;
         row_base <= '0;
         color    <= 8'h00;
`ifdef RECT_FILL_CHECKER_EN
         checker  <= 1'b0;
`endif
      end else if (accept) begin
         x_start  <= cmd_x;
         x_end    <= x_clip;
         y_end    <= y_clip;
         cx       <= cmd_x;
         cy       <= cmd_y;
         row_base <= AW'(row_offset(cmd_y));
         color    <= cmd_color;
`ifdef RECT_FILL_CHECKER_EN
         checker  <= cmd_checker;
`endif
      end else if (wr_done) begin
         if (row_last) begin
            cx       <= x_start;
            cy       <= cy + 7'd1;
            row_base <= row_base + AW'(SCR_W);
         end else begin
            cx       <= cx + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_rect_fill.sv
// ---------------------------------------------------------------------------
// tb_rect_fill
// Directed bench for rect_fill. A reference list of (addr, data) writes is
// built from the rectangle geometry with plain loops; a compare process
// checks every presented write against the head of that list. Completion
// latencies and key addresses are hand-computed literals.
// Build with +define+RECT_FILL_CHECKER_EN to include the checkerboard test.
// ---------------------------------------------------------------------------
module tb_rect_fill;
   import vga_pkg::*;

   logic        pclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_x = 8'd0;
   logic [6:0]  cmd_y = 7'd0;
   logic [7:0]  cmd_w = 8'd0;
   logic [6:0]  cmd_h = 7'd0;
   logic [7:0]  cmd_color = 8'h00;
`ifdef RECT_FILL_CHECKER_EN
   logic        cmd_checker = 1'b0;
`endif
   logic        vram_we;
   logic [13:0] vram_addr;
   logic [7:0]  vram_data;
   logic        vram_wait = 1'b0;
   logic        busy;
   logic        done;

   rect_fill dut (
      .pclk        (pclk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .cmd_w       (cmd_w),
      .cmd_h       (cmd_h),
      .cmd_color   (cmd_color),
`ifdef RECT_FILL_CHECKER_EN
      .cmd_checker (cmd_checker),
`endif
      .vram_we     (vram_we),
      .vram_addr   (vram_addr),
      .vram_data   (vram_data),
      .vram_wait   (vram_wait),
      .busy        (busy),
      .done        (done)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   wr_t log_q[$];

   int n_checks = 0;
   int n_err    = 0;
   bit done_flag = 1'b0;
   int done_cyc  = 0;
   int hold171   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Reference writes: raster scan of the rectangle clipped to the screen.
   task automatic model_fill(input int x, input int y, input int w, input int h,
                             input int col, input bit chk);
      int xe;
      int ye;
      xe = (x + w < SCR_W) ? x + w : SCR_W;
      ye = (y + h < SCR_H) ? y + h : SCR_H;
      if (w == 0 || h == 0) begin
         xe = x;
         ye = y;
      end
      for (int yy = y; yy < ye; yy++) begin
         for (int xx = x; xx < xe; xx++) begin
            wr_t e;
            e.addr = yy * SCR_W + xx;
            e.data = (chk && ((((xx / 4) + (yy / 4)) % 2) == 1)) ? 0 : col;
            exp_q.push_back(e);
         end
      end
   endtask

   // Compare process: inputs change on the falling edge, so one time unit
   // later both the DUT outputs and the inputs for the next rising edge are
   // settled.
   always @(negedge pclk) begin
      #1;
      if (reset_n) begin
         check("busy", busy, vram_we | done);
         check("cmd_ready", cmd_ready, !(vram_we | done));
         if (vram_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               check("vram_addr", vram_addr, exp_q[0].addr);
               check("vram_data", vram_data, exp_q[0].data);
               if (vram_addr == 14'd171) hold171++;
               if (!vram_wait) begin
                  wr_t e;
                  e.addr = int'(vram_addr);
                  e.data = int'(vram_data);
                  log_q.push_back(e);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (done) begin
            check("done_after_all_writes", exp_q.size(), 0);
            done_flag = 1'b1;
            done_cyc  = cyc;
         end
      end
   end

   // Issue one command, wait (bounded) for done and check its latency and
   // the cmd_ready return one cycle later.
   task automatic run_cmd(input string tag, input int x, input int y, input int w,
                          input int h, input int col, input bit chk, input int exp_lat);
      int n0;
      int guard;
      model_fill(x, y, w, h, col, chk);
      log_q.delete();
      done_flag = 1'b0;
      hold171   = 0;
      guard     = 0;
      @(negedge pclk);
      cmd_x     = 8'(x);
      cmd_y     = 7'(y);
      cmd_w     = 8'(w);
      cmd_h     = 7'(h);
      cmd_color = 8'(col);
`ifdef RECT_FILL_CHECKER_EN
      cmd_checker = chk;
`endif
      cmd_valid = 1'b1;
      n0 = cyc;
      @(negedge pclk);
      cmd_valid = 1'b0;
      #2;
      while (!done_flag && guard < 2000) begin
         @(negedge pclk);
         #2;
         guard++;
      end
      check({tag, "_done_seen"}, done_flag, 1);
      if (done_flag) check({tag, "_done_latency"}, done_cyc - n0, exp_lat);
      @(negedge pclk);
      #2;
      check({tag, "_ready_after_done"}, cmd_ready, 1);
      check({tag, "_no_pending"}, exp_q.size(), 0);
   endtask

   // Stall helper: holds vram_wait for 3 cycles on the first cycle addr 171
   // is presented, and pulses cmd_valid while the engine is busy.
   task automatic stall_driver();
      int g;
      g = 0;
      while (!(vram_we && vram_addr == 14'd170) && g < 50) begin
         @(negedge pclk);
         g++;
      end
      check("stall_saw_170", {31'd0, vram_we && vram_addr == 14'd170}, 1);
      @(negedge pclk);
      check("stall_first_171", vram_addr, 171);
      vram_wait = 1'b1;
      cmd_x     = 8'd50;
      cmd_valid = 1'b1;
      @(negedge pclk);
      cmd_valid = 1'b0;
      cmd_x     = 8'd10;
      @(negedge pclk);
      @(negedge pclk);
      vram_wait = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_a[4];
      int exp_d[4];

      // Reset state
      repeat (3) @(negedge pclk);
      #1;
      check("rst_vram_we", vram_we, 0);
      check("rst_vram_addr", vram_addr, 0);
      check("rst_vram_data", vram_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge pclk);
      reset_n = 1'b1;
      @(negedge pclk);
      #2;
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_we", vram_we, 0);

      // Basic 2x2 fill
      run_cmd("basic", 0, 0, 2, 2, 'hE0, 1'b0, 5);
      exp_a = '{0, 1, 160, 161};
      check("basic_count", log_q.size(), 4);
      for (int i = 0; i < 4 && i < log_q.size(); i++) begin
         check("basic_addr", log_q[i].addr, exp_a[i]);
         check("basic_data", log_q[i].data, 'hE0);
      end

      // Clipped at the bottom-right corner
      run_cmd("clip", 158, 99, 5, 3, 'h1C, 1'b0, 3);
      check("clip_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("clip_addr0", log_q[0].addr, 15998);
         check("clip_addr1", log_q[1].addr, 15999);
      end

      // Degenerate commands
      run_cmd("degen_w0", 5, 5, 0, 4, 'h03, 1'b0, 1);
      check("degen_w0_count", log_q.size(), 0);
      run_cmd("degen_x200", 200, 5, 4, 4, 'h03, 1'b0, 1);
      check("degen_x200_count", log_q.size(), 0);
      run_cmd("degen_y100", 5, 100, 4, 4, 'h03, 1'b0, 1);
      check("degen_y100_count", log_q.size(), 0);

      // Stall with a busy-time cmd_valid pulse
      fork
         run_cmd("stall", 10, 1, 3, 1, 'h92, 1'b0, 7);
         stall_driver();
      join
      exp_a[0] = 170; exp_a[1] = 171; exp_a[2] = 172;
      check("stall_count", log_q.size(), 3);
      for (int i = 0; i < 3 && i < log_q.size(); i++) begin
         check("stall_addr", log_q[i].addr, exp_a[i]);
      end
      check("stall_hold_171", hold171, 4);

      // Multi-row fill spanning a row boundary on the right edge
      run_cmd("wide", 157, 20, 10, 3, 'h55, 1'b0, 10);
      check("wide_count", log_q.size(), 9);
      if (log_q.size() == 9) begin
         check("wide_first", log_q[0].addr, 3357);
         check("wide_row2", log_q[3].addr, 3517);
         check("wide_last", log_q[8].addr, 3679);
      end

`ifdef RECT_FILL_CHECKER_EN
      run_cmd("checker", 2, 0, 4, 1, 'hFF, 1'b1, 5);
      exp_d = '{'hFF, 'hFF, 'h00, 'h00};
      check("checker_count", log_q.size(), 4);
      for (int i = 0; i < 4 && i < log_q.size(); i++) begin
         check("checker_addr", log_q[i].addr, 2 + i);
         check("checker_data", log_q[i].data, exp_d[i]);
      end
      run_cmd("checker_off", 2, 0, 4, 1, 'hFF, 1'b0, 5);
      check("checker_off_data", (log_q.size() == 4) ? log_q[2].data : -1, 'hFF);
`else
      exp_d = '{'h00, 'h00, 'h00, 'h00};
      check("solid_build_pad", exp_d[0] + log_q.size(), 9);
`endif

      // Reset in the middle of a long fill
      model_fill(0, 10, 20, 5, 'hAA, 1'b0);
      @(negedge pclk);
      cmd_x = 8'd0; cmd_y = 7'd10; cmd_w = 8'd20; cmd_h = 7'd5;
      cmd_color = 8'hAA;
`ifdef RECT_FILL_CHECKER_EN
      cmd_checker = 1'b0;
`endif
      cmd_valid = 1'b1;
      @(negedge pclk);
      cmd_valid = 1'b0;
      repeat (10) @(negedge pclk);
      #2;
      check("midrst_running", vram_we, 1);
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_we", vram_we, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      repeat (2) @(negedge pclk);
      reset_n = 1'b1;
      repeat (6) @(negedge pclk);
      #2;
      check("midrst_ready", cmd_ready, 1);
      check("midrst_no_we", vram_we, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
